// File: rtl/seg_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the seven-segment scan controller.
//   NIB_W       : width of one hex digit code
//   MAX_DIGITS  : widest display the blank helper can evaluate
//   DIG_OFF     : digit-select pattern with every digit dark (active-low)
//   digit_blank : decides whether digit i is dark for a given active data set
// ---------------------------------------------------------------------------
package disp_pkg;

    localparam int NIB_W      = 4;
    localparam int MAX_DIGITS = 16;
    localparam int MAX_VW     = MAX_DIGITS * NIB_W;

    localparam logic [MAX_DIGITS-1:0] DIG_OFF = '1;

    // A digit is dark when it is disabled, or when leading-zero blanking is on,
    // it is not the rightmost digit, and it and every digit to its left carry
    // neither a non-zero nibble nor a dot. Inputs are zero-extended to
    // MAX_DIGITS; ndig is the real display width.
    function automatic logic digit_blank(
        input logic [MAX_VW-1:0]     value,
        input logic [MAX_DIGITS-1:0] dots,
        input logic [MAX_DIGITS-1:0] en,
        input int                    i,
        input int                    ndig,
        input logic                  lz
    );
        logic all_zero;
        all_zero = 1'b1;
        for (int j = 0; j < MAX_DIGITS; j++) begin
            if (j >= i && j < ndig) begin
                if (value[j*NIB_W +: NIB_W] != '0 || dots[j]) begin
                    all_zero = 1'b0;
                end
            end
        end
        return !en[i] || (lz && (i != 0) && all_zero);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_scan_tick.sv
// ---------------------------------------------------------------------------
// scan_tick
// Free-running prescaler that produces one tick every SCAN_DIV clocks.
//   clk  : system clock
//   rst  : asynchronous active-high reset (count returns to 0)
//   tick : high for the one cycle in which the count sits at SCAN_DIV-1
// ---------------------------------------------------------------------------
module scan_tick #(
    parameter int SCAN_DIV = 5000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int                CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for a DIGITS-wide seven-segment display.
// Holds a double-buffered hex value, steps one digit per SCAN_DIV clocks and
// presents that digit's nibble/dot plus the active-low digit select.
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   load        : one-cycle strobe capturing value/dots/en
//   value       : nibble i at value[4i+3:4i], digit 0 rightmost
//   dots        : decimal point per digit
//   en          : per-digit enable, 0 keeps the digit dark
//   nibble      : hex code of the current digit (to the segment decoder)
//   dot         : dot of the current digit
//   an          : active-low digit select, at most one bit low
//   frame_start : one-cycle pulse when digit 0 becomes current
// ---------------------------------------------------------------------------
module seg_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 5000,
    parameter int LZ_BLANK = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [NIB_W*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]         dots,
    input  logic [DIGITS-1:0]         en,
    output logic [NIB_W-1:0]          nibble,
    output logic                      dot,
    output logic [DIGITS-1:0]         an,
    output logic                      frame_start
);

    localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam int               VW       = NIB_W * DIGITS;

    logic tick;
    logic boundary;

    logic [IDX_W-1:0]  idx_q,        idx_d;
    logic              pend_flag_q,  pend_flag_d;
    logic [VW-1:0]     pend_val_q,   pend_val_d;
    logic [DIGITS-1:0] pend_dots_q,  pend_dots_d;
    logic [DIGITS-1:0] pend_en_q,    pend_en_d;
    logic [VW-1:0]     act_val_q,    act_val_d;
    logic [DIGITS-1:0] act_dots_q,   act_dots_d;
    logic [DIGITS-1:0] act_en_q,     act_en_d;
    logic [NIB_W-1:0]  nibble_q,     nibble_d;
    logic              dot_q,        dot_d;
    logic [DIGITS-1:0] an_q,         an_d;
    logic              frame_start_q, frame_start_d;
    logic              blank_next;

    scan_tick #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // The frame boundary is the tick that wraps the index back to digit 0.
    assign boundary = tick && (idx_q == IDX_LAST);

    // Index and buffer update.
    always_comb begin
        idx_d       = idx_q;
        pend_flag_d = pend_flag_q;
        pend_val_d  = pend_val_q;
        pend_dots_d = pend_dots_q;
        pend_en_d   = pend_en_q;
        act_val_d   = act_val_q;
        act_dots_d  = act_dots_q;
        act_en_d    = act_en_q;

        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        if (boundary) begin
            // A load landing on the boundary bypasses the pending buffer, so
            // it wins over anything still pending from earlier in the frame.
            if (load) begin
                act_val_d   = value;
                act_dots_d  = dots;
                act_en_d    = en;
                pend_flag_d = 1'b0;
            end else if (pend_flag_q) begin
                act_val_d   = pend_val_q;
                act_dots_d  = pend_dots_q;
                act_en_d    = pend_en_q;
                pend_flag_d = 1'b0;
            end
        end else if (load) begin
            pend_val_d  = value;
            pend_dots_d = dots;
            pend_en_d   = en;
            pend_flag_d = 1'b1;
        end
    end

    // Outputs are computed from the next index and next active data so the
    // digit-0 slot of a frame already reflects a buffer swap at that edge.
    always_comb begin
        blank_next    = digit_blank(MAX_VW'(act_val_d), MAX_DIGITS'(act_dots_d),
                                    MAX_DIGITS'(act_en_d), int'(idx_d), DIGITS,
                                    LZ_BLANK != 0);
        nibble_d      = nibble_q;
        dot_d         = dot_q;
        an_d          = an_q;
        frame_start_d = boundary;
        if (tick) begin
            nibble_d = act_val_d[{idx_d, 2'b00} +: NIB_W];
            dot_d    = act_dots_d[idx_d];
            an_d     = blank_next ? DIG_OFF[DIGITS-1:0] : ~(DIGITS'(1) << idx_d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q         <= IDX_LAST;
            pend_flag_q   <= 1'b0;
            pend_val_q    <= '0;
            pend_dots_q   <= '0;
            pend_en_q     <= '0;
            act_val_q     <= '0;
            act_dots_q    <= '0;
            act_en_q      <= '1;
            nibble_q      <= '0;
            dot_q         <= 1'b0;
            an_q          <= DIG_OFF[DIGITS-1:0];
            frame_start_q <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            pend_flag_q   <= pend_flag_d;
            pend_val_q    <= pend_val_d;
            pend_dots_q   <= pend_dots_d;
            pend_en_q     <= pend_en_d;
            act_val_q     <= act_val_d;
            act_dots_q    <= act_dots_d;
            act_en_q      <= act_en_d;
            nibble_q      <= nibble_d;
            dot_q         <= dot_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign nibble      = nibble_q;
    assign dot         = dot_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (leading-zero blanking on and off)
// share one stimulus; each expected slot is pushed to exp_q when a frame of
// data is committed and popped when the DUTs present that slot.
module tb_seg_scan_ctrl;

    localparam int DIGITS   = 8;
    localparam int SCAN_DIV = 4;
    localparam int EW       = 26;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        load  = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  dots  = '0;
    logic [7:0]  en    = '0;

    logic [3:0] nibble_a, nibble_b;
    logic       dot_a, dot_b;
    logic [7:0] an_a, an_b;
    logic       fs_a, fs_b;

    seg_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .LZ_BLANK(1)) u_dut_lz (
        .clk(clk), .rst(rst), .load(load), .value(value), .dots(dots), .en(en),
        .nibble(nibble_a), .dot(dot_a), .an(an_a), .frame_start(fs_a)
    );

    seg_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .LZ_BLANK(0)) u_dut_nolz (
        .clk(clk), .rst(rst), .load(load), .value(value), .dots(dots), .en(en),
        .nibble(nibble_b), .dot(dot_b), .an(an_b), .frame_start(fs_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Entry: {an_a, dot_a, nibble_a, an_b, dot_b, nibble_b}
    logic [EW-1:0] exp_q[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d checks=%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic tb_blank(input logic [31:0] v, input logic [7:0] d,
                                      input logic [7:0] e, input int i, input logic lz);
        if (!e[i]) return 1'b1;
        if (!lz || i == 0) return 1'b0;
        for (int j = i; j < DIGITS; j++) begin
            if (v[4*j +: 4] != 4'h0 || d[j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [12:0] tb_slot(input logic [31:0] v, input logic [7:0] d,
                                            input logic [7:0] e, input int k, input logic lz);
        logic [7:0] sel;
        sel = 8'h01 << k;
        return {tb_blank(v, d, e, k, lz) ? 8'hFF : ~sel, d[k], v[4*k +: 4]};
    endfunction

    task automatic push_frame(input logic [31:0] v, input logic [7:0] d, input logic [7:0] e);
        for (int k = 0; k < DIGITS; k++) begin
            exp_q.push_back({tb_slot(v, d, e, k, 1'b1), tb_slot(v, d, e, k, 1'b0)});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_load(input logic [31:0] v, input logic [7:0] d, input logic [7:0] e);
        value = v;
        dots  = d;
        en    = e;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (fs_a !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (fs_a !== 1'b1) $display("FAIL wait_frame: frame_start=%b after %0d cycles, required 1", fs_a, n);
        else n_pass++;
    endtask

    // Scoreboard stage: entered on the negedge where frame_start is high,
    // checks all slots of one frame and leaves on the next frame_start negedge.
    // Optionally strobes load at slot ld_k, cycle ld_c (sampled at the next edge).
    task automatic scoreboard_frame(input logic do_ld, input int ld_k, input int ld_c,
                                    input logic [31:0] v, input logic [7:0] d, input logic [7:0] e);
        logic [EW-1:0] exp_e;
        logic          exp_fs;
        for (int k = 0; k < DIGITS; k++) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_empty: slot %0d has no expected entry", k);
                exp_e = 'x;
            end else begin
                exp_e = exp_q.pop_front();
            end
            for (int c = 0; c < SCAN_DIV; c++) begin
                if (do_ld && k == ld_k && c == ld_c) begin
                    value = v;
                    dots  = d;
                    en    = e;
                    load  = 1'b1;
                end else begin
                    load  = 1'b0;
                end
                exp_fs = (k == 0 && c == 0);
                n_checks++;
                if ({an_a, dot_a, nibble_a} !== exp_e[25:13])
                    $display("FAIL slot_lz k=%0d c=%0d: an/dot/nib=%h/%b/%h required %h/%b/%h",
                             k, c, an_a, dot_a, nibble_a, exp_e[25:18], exp_e[17], exp_e[16:13]);
                else n_pass++;
                n_checks++;
                if ({an_b, dot_b, nibble_b} !== exp_e[12:0])
                    $display("FAIL slot_nolz k=%0d c=%0d: an/dot/nib=%h/%b/%h required %h/%b/%h",
                             k, c, an_b, dot_b, nibble_b, exp_e[12:5], exp_e[4], exp_e[3:0]);
                else n_pass++;
                n_checks++;
                if ({fs_a, fs_b} !== {exp_fs, exp_fs})
                    $display("FAIL frame_start k=%0d c=%0d: got %b%b required %b%b",
                             k, c, fs_a, fs_b, exp_fs, exp_fs);
                else n_pass++;
                @(negedge clk);
            end
        end
        load = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({an_a, dot_a, nibble_a, fs_a} !== {8'hFF, 1'b0, 4'h0, 1'b0})
            $display("FAIL reset_values_lz: an=%h dot=%b nib=%h fs=%b required FF/0/0/0", an_a, dot_a, nibble_a, fs_a);
        else n_pass++;
        n_checks++;
        if ({an_b, dot_b, nibble_b, fs_b} !== {8'hFF, 1'b0, 4'h0, 1'b0})
            $display("FAIL reset_values_nolz: an=%h dot=%b nib=%h fs=%b required FF/0/0/0", an_b, dot_b, nibble_b, fs_b);
        else n_pass++;
        rst = 1'b0;
        for (int c = 1; c < SCAN_DIV; c++) begin
            @(negedge clk);
            n_checks++;
            if ({an_a, an_b, fs_a, fs_b} !== {8'hFF, 8'hFF, 2'b00})
                $display("FAIL reset_pre_tick c=%0d: an=%h/%h fs=%b%b required FF/FF 00", c, an_a, an_b, fs_a, fs_b);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if ({an_a, nibble_a, dot_a, fs_a} !== {8'hFE, 4'h0, 1'b0, 1'b1})
            $display("FAIL reset_first_tick: an=%h nib=%h dot=%b fs=%b required FE/0/0/1", an_a, nibble_a, dot_a, fs_a);
        else n_pass++;
        n_checks++;
        if ({an_b, nibble_b, fs_b} !== {8'hFE, 4'h0, 1'b1})
            $display("FAIL reset_first_tick_nolz: an=%h nib=%h fs=%b required FE/0/1", an_b, nibble_b, fs_b);
        else n_pass++;
    endtask

    task automatic test_full_scan();
        do_load(32'h1234ABCD, 8'h00, 8'hFF);
        wait_frame();
        push_frame(32'h1234ABCD, 8'h00, 8'hFF);
        scoreboard_frame(1'b0, 0, 0, '0, '0, '0);
    endtask

    task automatic test_lz_blank();
        do_load(32'h000000F0, 8'h00, 8'hFF);
        wait_frame();
        push_frame(32'h000000F0, 8'h00, 8'hFF);
        scoreboard_frame(1'b0, 0, 0, '0, '0, '0);
    endtask

    task automatic test_dot_blank();
        do_load(32'h00000000, 8'h08, 8'hFF);
        wait_frame();
        push_frame(32'h00000000, 8'h08, 8'hFF);
        scoreboard_frame(1'b0, 0, 0, '0, '0, '0);
    endtask

    task automatic test_enable_mask();
        logic [7:0] rnd_dots;
        do_load(32'h00A00305, 8'h00, 8'hDB);
        wait_frame();
        push_frame(32'h00A00305, 8'h00, 8'hDB);
        scoreboard_frame(1'b0, 0, 0, '0, '0, '0);
        rnd_dots = 8'($urandom_range(0, 255));
        do_load(32'h0F00C001, rnd_dots, 8'hFF);
        wait_frame();
        push_frame(32'h0F00C001, rnd_dots, 8'hFF);
        scoreboard_frame(1'b0, 0, 0, '0, '0, '0);
    endtask

    // Entered on a frame_start negedge still showing the last loaded data.
    task automatic test_mid_frame_load();
        push_frame(32'h0F00C001, dots, 8'hFF);
        scoreboard_frame(1'b1, 3, 0, 32'h11111111, 8'h00, 8'hFF);
        push_frame(32'h11111111, 8'h00, 8'hFF);
        scoreboard_frame(1'b0, 0, 0, '0, '0, '0);
    endtask

    task automatic test_boundary_load();
        push_frame(32'h11111111, 8'h00, 8'hFF);
        scoreboard_frame(1'b1, DIGITS - 1, SCAN_DIV - 1, 32'h87654321, 8'h21, 8'hFF);
        push_frame(32'h87654321, 8'h21, 8'hFF);
        scoreboard_frame(1'b0, 0, 0, '0, '0, '0);
    endtask

    task automatic test_back_to_back();
        do_load(32'hDEADBEEF, 8'hFF, 8'hFF);
        do_load(32'h00000C0C, 8'h00, 8'hFF);
        wait_frame();
        push_frame(32'h00000C0C, 8'h00, 8'hFF);
        scoreboard_frame(1'b0, 0, 0, '0, '0, '0);
    endtask

    task automatic test_reset_mid_frame();
        do_load(32'h99999999, 8'h55, 8'h0F);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({an_a, dot_a, nibble_a, fs_a, an_b, fs_b} !== {8'hFF, 1'b0, 4'h0, 1'b0, 8'hFF, 1'b0})
            $display("FAIL reset_async: an=%h dot=%b nib=%h fs=%b an_b=%h required FF/0/0/0/FF",
                     an_a, dot_a, nibble_a, fs_a, an_b);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c < SCAN_DIV; c++) begin
            @(negedge clk);
            n_checks++;
            if ({an_a, an_b, fs_a} !== {8'hFF, 8'hFF, 1'b0})
                $display("FAIL rerst_pre_tick c=%0d: an=%h/%h fs=%b required FF/FF/0", c, an_a, an_b, fs_a);
            else n_pass++;
        end
        @(negedge clk);
        // The discarded pending load must never reach the display.
        push_frame(32'h00000000, 8'h00, 8'hFF);
        scoreboard_frame(1'b0, 0, 0, '0, '0, '0);
        push_frame(32'h00000000, 8'h00, 8'hFF);
        scoreboard_frame(1'b0, 0, 0, '0, '0, '0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_full_scan();
        test_lz_blank();
        test_dot_blank();
        test_enable_mask();
        test_mid_frame_load();
        test_boundary_load();
        test_back_to_back();
        test_reset_mid_frame();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: %0d entries remain, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
